// File: rtl/rr_index_arbiter_pkg.sv
// Shared types and helpers for the round-robin index arbiter and its index consumers.
package rr_index_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  // Index width for an n-way select; a single requester still gets a 1-bit index.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_index_arbiter_pick.sv
// Combinational round-robin search: lowest set request at or above ptr, else lowest overall.
module rr_pick
  import rr_index_arbiter_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 4,
  parameter int unsigned SEL_WIDTH   = sel_width(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0] request_i,
  input  logic [SEL_WIDTH-1:0]   ptr_i,
  output logic [SEL_WIDTH-1:0]   winner_o,
  output logic                   any_valid_o
);

  logic [INPUT_WIDTH-1:0] masked;
  logic                   masked_hit;

  always_comb begin
    masked     = '0;
    masked_hit = 1'b0;
    winner_o   = '0;
    for (int i = 0; i < int'(INPUT_WIDTH); i++) begin
      masked[i] = request_i[i] && (i >= int'(ptr_i));
    end
    // Descending scan so the lowest matching index is the last assignment.
    for (int i = int'(INPUT_WIDTH) - 1; i >= 0; i--) begin
      if (masked[i]) begin
        winner_o   = SEL_WIDTH'(unsigned'(i));
        masked_hit = 1'b1;
      end
    end
    if (!masked_hit) begin
      for (int i = int'(INPUT_WIDTH) - 1; i >= 0; i--) begin
        if (request_i[i]) begin
          winner_o = SEL_WIDTH'(unsigned'(i));
        end
      end
    end
  end

  assign any_valid_o = |request_i;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter emitting a registered binary winner index; grants are held until done_i.
module rr_index_arbiter
  import rr_index_arbiter_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 4,
  parameter int unsigned SEL_WIDTH   = sel_width(INPUT_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [INPUT_WIDTH-1:0] request_i,
  input  logic                   done_i,
  output logic [SEL_WIDTH-1:0]   select_o,
  output logic                   valid_o
);

  localparam logic [SEL_WIDTH-1:0] LastIdx = SEL_WIDTH'(INPUT_WIDTH - 1);

  arb_state_e           state_q;
  logic [SEL_WIDTH-1:0] select_q;
  logic                 valid_q;
  logic [SEL_WIDTH-1:0] ptr_q;
  logic [SEL_WIDTH-1:0] ptr_next;
  logic [SEL_WIDTH-1:0] pick_ptr;
  logic [SEL_WIDTH-1:0] winner;
  logic                 any_valid;

  assign ptr_next = (select_q == LastIdx) ? '0 : select_q + 1'b1;
  // While a grant is active the only arbitration that matters is the one on done_i,
  // which must already use the advanced pointer.
  assign pick_ptr = (state_q == StGrant) ? ptr_next : ptr_q;

  rr_pick #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_pick (
    .request_i  (request_i),
    .ptr_i      (pick_ptr),
    .winner_o   (winner),
    .any_valid_o(any_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      select_q <= '0;
      valid_q  <= 1'b0;
      ptr_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable_i && any_valid) begin
            select_q <= winner;
            valid_q  <= 1'b1;
            state_q  <= StGrant;
          end
        end
        StGrant: begin
          if (done_i) begin
            ptr_q <= ptr_next;
            if (enable_i && any_valid) begin
              select_q <= winner;
            end else begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign select_o = select_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Scoreboard bench: 4-way and 5-way arbiters driven together against a rotating-search model.
module tb_rr_index_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req4;
  logic [4:0] req5;
  logic       done4;
  logic       done5;
  logic [1:0] sel4;
  logic       val4;
  logic [2:0] sel5;
  logic       val5;

  always #5 clk = ~clk;

  rr_index_arbiter #(.INPUT_WIDTH(4)) u_dut4 (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
    .request_i(req4),
    .done_i   (done4),
    .select_o (sel4),
    .valid_o  (val4)
  );

  rr_index_arbiter #(.INPUT_WIDTH(5)) u_dut5 (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
    .request_i(req5),
    .done_i   (done5),
    .select_o (sel5),
    .valid_o  (val5)
  );

  typedef struct {
    bit v4;
    int s4;
    bit c4;
    bit v5;
    int s5;
    bit c5;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: owner index (-1 when idle), pointer, last shown select.
  int own[2];
  int ptr[2];
  int sel[2];

  function automatic int pick(int w, int p, logic [4:0] r);
    for (int k = 0; k < w; k++) begin
      int idx;
      idx = (p + k) % w;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void check(string name, int act, int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endfunction

  task automatic step(bit r, bit e, logic [3:0] r4, logic [4:0] r5, bit d4, bit d5);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; req4 = r4; req5 = r5; done4 = d4; done5 = d5;
    for (int j = 0; j < 2; j++) begin
      int         w;
      logic [4:0] rq;
      bit         d;
      w  = (j == 0) ? 4 : 5;
      rq = (j == 0) ? {1'b0, r4} : r5;
      d  = (j == 0) ? d4 : d5;
      if (r) begin
        own[j] = -1; ptr[j] = 0; sel[j] = 0;
      end else if (own[j] >= 0) begin
        if (d) begin
          ptr[j] = (own[j] + 1) % w;
          own[j] = (e && rq != 0) ? pick(w, ptr[j], rq) : -1;
        end
      end else if (e && rq != 0) begin
        own[j] = pick(w, ptr[j], rq);
      end
      if (own[j] >= 0) sel[j] = own[j];
    end
    x.v4 = own[0] >= 0; x.s4 = sel[0]; x.c4 = x.v4 || r;
    x.v5 = own[1] >= 0; x.s5 = sel[1]; x.c5 = x.v5 || r;
    sb.push_back(x);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("valid4", int'(val4), int'(x.v4));
        if (x.c4) check("select4", int'(sel4), x.s4);
        check("valid5", int'(val5), int'(x.v5));
        if (x.c5) check("select5", int'(sel5), x.s5);
        if (val5) check("select5_range", int'(sel5 <= 3'd4), 1);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; req4 = '0; req5 = '0; done4 = 1'b0; done5 = 1'b0;
    own = '{-1, -1}; ptr = '{0, 0}; sel = '{0, 0};
    // Reset with everything requesting, then release.
    step(1, 1, 4'b1111, 5'b11111, 0, 0);
    step(1, 1, 4'b1111, 5'b11111, 0, 0);
    step(0, 1, 4'b1111, 5'b10001, 0, 0);
    // Rotation, back-to-back grants.
    repeat (5) step(0, 1, 4'b1111, 5'b10001, 1, 1);
    step(0, 1, 4'b0000, 5'b00000, 1, 1);
    // Hold and release with the owner dropping its request.
    step(0, 1, 4'b0100, 5'b00100, 0, 0);
    repeat (5) step(0, 1, 4'b0000, 5'b00000, 0, 0);
    step(0, 1, 4'b0000, 5'b00000, 1, 1);
    step(0, 1, 4'b0000, 5'b00000, 1, 1);
    // Wrap and skip from ptr=3.
    step(0, 1, 4'b0011, 5'b00011, 0, 0);
    step(0, 1, 4'b0011, 5'b00011, 1, 1);
    step(0, 1, 4'b0000, 5'b00000, 1, 1);
    // Enable gating, then disable mid-grant.
    repeat (3) step(0, 0, 4'b1000, 5'b01000, 0, 0);
    step(0, 1, 4'b1000, 5'b01000, 0, 0);
    repeat (3) step(0, 0, 4'b0000, 5'b00000, 0, 0);
    step(0, 0, 4'b1000, 5'b01000, 1, 1);
    // Sole requester is re-granted; then reset mid-grant.
    step(0, 1, 4'b0010, 5'b10000, 0, 0);
    step(0, 1, 4'b0010, 5'b10000, 1, 1);
    step(1, 1, 4'b0010, 5'b10000, 0, 0);
    step(0, 0, 4'b0000, 5'b00000, 0, 0);
    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           4'($urandom), 5'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
- Round-robin arbiter that emits a binary winner index rather than a one-hot grant.
- Sits directly upstream of tree_decoder: select_o drives its select_i and valid_o drives its enable_i, so the decoder produces the one-hot grant.
- Holds each grant until the owner signals completion, then advances a fairness pointer.

Parameters:
INPUT_WIDTH, 4, number of requesters. Legal range is 1 or more; powers of two are not required.
SEL_WIDTH, $clog2(max(INPUT_WIDTH,2)), index width, matching tree_decoder's select width. Derived; not overridden.

Ports:
clk_i  input  1  single clock, rising edge.
rst_i  input  1  synchronous, active-high reset.
enable_i  input  1  permits new grants. Does not revoke a grant in progress.
request_i  input  INPUT_WIDTH  request vector, bit n = requester n.
done_i  input  1  current owner releases the grant. Only sampled while valid_o=1.
select_o  output  SEL_WIDTH  registered winner index.
valid_o  output  1  registered flag: a grant is active and select_o is meaningful.

Behaviour:
- Clock and reset: one clock (clk_i). Reset rst_i is synchronous and active-high.
- Reset state, sampled on the clk_i edge with rst_i=1:
  - state=IDLE, valid_o=0, select_o=0, ptr=0.
  - rst_i overrides every other input, including mid-grant: the grant is dropped on the next edge.
- State IDLE:
  - If enable_i=1 and request_i!=0, compute winner = lowest set index >= ptr, wrapping to index 0 after INPUT_WIDTH-1.
  - Next edge: select_o=winner, valid_o=1, state=GRANT. Latency is one cycle from request to valid_o.
  - Otherwise hold, with valid_o=0.
- State GRANT:
  - select_o and valid_o are stable.
  - request_i changes, including the owner dropping its request, are ignored until done_i.
- done_i=1 in GRANT:
  - ptr_next = select_o+1, wrapping to 0 when select_o=INPUT_WIDTH-1. Never equals INPUT_WIDTH.
  - Re-arbitrate in the same cycle using ptr_next.
  - If enable_i=1 and request_i!=0: next edge loads the new winner and valid_o stays 1. Back-to-back grants, no bubble.
  - Otherwise: valid_o=0, state=IDLE, ptr=ptr_next. select_o keeps its last value; don't-care while valid_o=0.
  - If the departing owner is the only requester, it is re-granted.
- ptr updates only on done_i or reset. It never changes in IDLE without a completed grant.
- done_i while valid_o=0 has no effect.
- INPUT_WIDTH=1: select_o is always 0. Arbitration reduces to request_i[0]; SEL_WIDTH=1.
- Non-power-of-two INPUT_WIDTH: select_o never exceeds INPUT_WIDTH-1. Unused index codes are never produced.
- Request bits are sampled only in the arbitration cycle. The block stores no pending state per requester.

Decomposition:
- Shared package: arbiter state enum (IDLE, GRANT) and a sel_width function.
  - The function computes $clog2 of max(n,2), shared with tree_decoder users.
- One sub-module, rr_pick: combinational search.
  - Inputs: request vector and ptr. Outputs: winner index and any_valid.
  - Implemented as a masked priority search with wrap: search request_i & (mask >= ptr) first, else fall back to unmasked request_i.
  - rr_index_arbiter holds only the FSM and registers.

Test Plan (INPUT_WIDTH=4 unless noted; outputs checked one edge after stimulus):
1. Reset: rst_i=1 for 2 cycles with request_i=4'b1111 -> valid_o=0, select_o=0. After release: select_o=0, valid_o=1.
2. Rotation: hold request_i=4'b1111, enable_i=1, pulse done_i each grant -> select_o sequence 0,1,2,3,0 with valid_o continuously 1.
3. Hold and release: request_i=4'b0100, grant select_o=2; drop request_i to 0 without done_i for 5 cycles -> select_o=2, valid_o=1 held. Then done_i -> valid_o=0, and next grant search starts at 3.
4. Wrap and skip: ptr=3 (after granting 2), request_i=4'b0011 -> select_o=0. Then done_i -> select_o=1.
5. Enable gating: enable_i=0, request_i=4'b1000 -> valid_o stays 0. Raise enable_i -> select_o=3 after one cycle. Drop enable_i mid-grant -> grant held until done_i.
6. INPUT_WIDTH=5: request_i=5'b10001 with rotation -> select_o alternates 4,0,4. Values 5–7 never appear. Also drive select_o into a tree_decoder and check data_o == 1<<select_o while valid_o=1.
